spi_dac_arbiter: RTL

- Shares one SPI DAC frame driver between NREQ independent requesters using round-robin arbitration.
- Latches the winner's channel address and 12-bit code, then builds the 24-bit DAC frame {CMD, addr[3:0], code[11:0], 4'b0000}.
- Issues the frame to the driver with a start pulse, waits for the driver's done pulse, then acknowledges the requester.
- Sits between the CPU/peripheral update sources and the SPI DAC serializer.

---
 rtl/spi_dac_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_dac_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_dac_arbiter
// Brief    : Round-robin share of one SPI DAC frame driver among NREQ sources.
//            Optional WAIT watchdog compiled in with SPI_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_dac_arbiter #(
    parameter int         NREQ      = 4,
    parameter logic [3:0] CMD       = 4'b0011,
    parameter int         WD_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [4*NREQ-1:0]       req_addr,
    input  logic [12*NREQ-1:0]      req_data,
    output logic [NREQ-1:0]         ack,
    output logic [23:0]             drv_frame,
    output logic                    drv_start,
    input  logic                    drv_busy,
    input  logic                    drv_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    arb_busy,
    output logic                    err
);

    localparam int                c_gw      = $clog2(NREQ);
    localparam logic [c_gw-1:0]   c_last_id = c_gw'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [c_gw-1:0]   r_grant;
    logic [c_gw-1:0]   w_winner, w_lo, w_hi;
    logic              w_hi_v;
    logic [3:0]        w_addr;
    logic [11:0]       w_data;
    logic [NREQ-1:0]   r_ack, w_ack_nx;
    logic [23:0]       r_frame;
    logic              r_start, w_start_nx;
    logic              r_busy, w_busy_nx;
    logic              w_timeout;

    if ((NREQ < 2) || (NREQ > 8) || (WD_CYCLES < 1)) begin : g_param_check
        $error("spi_dac_arbiter: parameter out of range");
    end

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_lo   = r_grant;
        w_hi   = r_grant;
        w_hi_v = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_lo = j[c_gw-1:0];
                if (j[c_gw-1:0] > r_grant) begin
                    w_hi   = j[c_gw-1:0];
                    w_hi_v = 1'b1;
                end
            end
        end
        w_winner = w_hi_v ? w_hi : w_lo;
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == i[c_gw-1:0]) begin
                w_addr = req_addr[4*i +: 4];
                w_data = req_data[12*i +: 12];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (|req) w_next = S_LOAD;
            S_LOAD:  if (!drv_busy) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (drv_done || w_timeout) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_start_nx = (w_next == S_START);
        w_busy_nx  = (w_next != S_IDLE);
        w_ack_nx   = '0;
        if (w_next == S_ACK) begin
            w_ack_nx[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= c_last_id;
            r_ack   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_frame <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_ack_nx;
            r_start <= w_start_nx;
            r_busy  <= w_busy_nx;
            if (r_state == S_IDLE && (|req)) begin
                r_grant <= w_winner;
            end
            // Re-sampled every LOAD cycle so a stalled frame carries the freshest code.
            if (r_state == S_LOAD) begin
                r_frame <= {CMD, w_addr, w_data, 4'b0000};
            end
        end
    end

`ifdef SPI_ARB_WATCHDOG_EN
    localparam int c_wd_w = $clog2(WD_CYCLES + 1);

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_err;

    // A drv_done in the expiring cycle takes precedence over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !drv_done &&
                       (r_wd_cnt == c_wd_w'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign ack       = r_ack;
    assign drv_frame = r_frame;
    assign drv_start = r_start;
    assign grant_id  = r_grant;
    assign arb_busy  = r_busy;

endmodule
`default_nettype wire
